// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
//   hz_state_e : memory-wait FSM states (RUN / MEM_WAIT / FAULT)
//   FWD_*      : forward-select encodings driven onto the EX operand muxes
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FAULT    = 2'd2
  } hz_state_e;

  localparam logic [1:0] FWD_REG = 2'b00;  // operand from register file
  localparam logic [1:0] FWD_MEM = 2'b01;  // operand from MEM-stage result
  localparam logic [1:0] FWD_WB  = 2'b10;  // operand from WB-stage result

endpackage

// File: rtl/pipe_fwd_unit.sv
// Forward-select logic for the two EX-stage operands.
// Only instantiated when the top is built with PIPE_FWD_EN.
// Ports:
//   ex_src1, ex_src2      in  EX-stage source register indices
//   mem_wb_en, mem_dest   in  MEM-stage writeback enable / destination
//   wb_wb_en, wb_dest     in  WB-stage writeback enable / destination
//   fwd_sel_a, fwd_sel_b  out operand select (FWD_REG / FWD_MEM / FWD_WB)
// The MEM stage holds the younger result, so it wins over WB.
module pipe_fwd_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 4
) (
  input  logic [REG_ADDR_W-1:0] ex_src1,
  input  logic [REG_ADDR_W-1:0] ex_src2,
  input  logic                  mem_wb_en,
  input  logic [REG_ADDR_W-1:0] mem_dest,
  input  logic                  wb_wb_en,
  input  logic [REG_ADDR_W-1:0] wb_dest,
  output logic [1:0]            fwd_sel_a,
  output logic [1:0]            fwd_sel_b
);

  function automatic logic [1:0] pick_src(input logic [REG_ADDR_W-1:0] src,
                                          input logic                  m_en,
                                          input logic [REG_ADDR_W-1:0] m_dst,
                                          input logic                  w_en,
                                          input logic [REG_ADDR_W-1:0] w_dst);
    logic [1:0] sel;
    sel = FWD_REG;
    if (m_en && (m_dst == src)) begin
      sel = FWD_MEM;
    end else if (w_en && (w_dst == src)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

  always_comb begin
    fwd_sel_a = pick_src(ex_src1, mem_wb_en, mem_dest, wb_wb_en, wb_dest);
    fwd_sel_b = pick_src(ex_src2, mem_wb_en, mem_dest, wb_wb_en, wb_dest);
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central freeze/flush controller for the IF/ID, ID/EX, EX/MEM and MEM/WB
// pipeline registers and the PC.
// Build option: define PIPE_FWD_EN to add operand forwarding (extra ports
// ex_src1/ex_src2/wb_wb_en/wb_dest/fwd_sel_a/fwd_sel_b); with forwarding only
// the load-use case stalls. Default build: every EX/MEM RAW match stalls.
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   id_src1/2, id_use1/2       ID-stage sources and their use flags
//   ex_wb_en, ex_dest          EX writeback enable / destination
//   ex_mem_read                EX instruction is a load
//   mem_wb_en, mem_dest        MEM writeback enable / destination
//   ex_br_taken                taken branch resolved in EX
//   mem_req, mem_ready         MEM-stage data memory handshake
//   pc_freeze, if_id_freeze    hold PC / IF/ID
//   if_id_flush, id_ex_flush   squash IF/ID / bubble into ID/EX
//   pipe_freeze                hold ID/EX, EX/MEM, MEM/WB
//   mem_timeout                sticky watchdog fault flag
//   stall_cnt                  saturating count of pc_freeze cycles
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_W  = 4,
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] id_src1,
  input  logic [REG_ADDR_W-1:0] id_src2,
  input  logic                  id_use1,
  input  logic                  id_use2,
  input  logic                  ex_wb_en,
  input  logic [REG_ADDR_W-1:0] ex_dest,
  input  logic                  ex_mem_read,
  input  logic                  mem_wb_en,
  input  logic [REG_ADDR_W-1:0] mem_dest,
  input  logic                  ex_br_taken,
  input  logic                  mem_req,
  input  logic                  mem_ready,
`ifdef PIPE_FWD_EN
  input  logic [REG_ADDR_W-1:0] ex_src1,
  input  logic [REG_ADDR_W-1:0] ex_src2,
  input  logic                  wb_wb_en,
  input  logic [REG_ADDR_W-1:0] wb_dest,
  output logic [1:0]            fwd_sel_a,
  output logic [1:0]            fwd_sel_b,
`endif
  output logic                  pc_freeze,
  output logic                  if_id_freeze,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic                  pipe_freeze,
  output logic                  mem_timeout,
  output logic [CNT_W-1:0]      stall_cnt
);

  localparam int unsigned      WC_W     = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WC_W-1:0]  WC_LIMIT = WC_W'(MEM_TIMEOUT);

  hz_state_e        state_q,     state_d;
  logic [WC_W-1:0]  wait_cnt_q,  wait_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic mem_stall;
  logic src1_ex_hit, src2_ex_hit, src1_mem_hit, src2_mem_hit;
  logic ex_hit, mem_hit, load_use, haz;

  // ---------------------------------------------------------------- hazards
  always_comb begin
    src1_ex_hit  = id_use1 && ex_wb_en  && (id_src1 == ex_dest);
    src2_ex_hit  = id_use2 && ex_wb_en  && (id_src2 == ex_dest);
    src1_mem_hit = id_use1 && mem_wb_en && (id_src1 == mem_dest);
    src2_mem_hit = id_use2 && mem_wb_en && (id_src2 == mem_dest);
    ex_hit       = src1_ex_hit || src2_ex_hit;
    mem_hit      = src1_mem_hit || src2_mem_hit;
    load_use     = ex_hit && ex_mem_read;
  end

`ifdef PIPE_FWD_EN
  // ALU results in EX/MEM are forwarded; only a load in EX cannot be.
  assign haz = load_use;

  pipe_fwd_unit #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_fwd (
    .ex_src1   (ex_src1),
    .ex_src2   (ex_src2),
    .mem_wb_en (mem_wb_en),
    .mem_dest  (mem_dest),
    .wb_wb_en  (wb_wb_en),
    .wb_dest   (wb_dest),
    .fwd_sel_a (fwd_sel_a),
    .fwd_sel_b (fwd_sel_b)
  );
`else
  // EX match split into load and non-load parts; together they cover any EX match.
  assign haz = load_use || (ex_hit && !ex_mem_read) || mem_hit;
`endif

  // ------------------------------------------------------- memory-wait FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      RUN: begin
        if (mem_req && !mem_ready) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = WC_W'(1);
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          state_d = RUN;
        end else if (wait_cnt_q == WC_LIMIT) begin
          state_d = FAULT;
        end else begin
          wait_cnt_d = wait_cnt_q + WC_W'(1);
        end
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // ------------------------------------------------------ pipeline controls
  always_comb begin
    mem_stall    = (mem_req && !mem_ready) || (state_q == FAULT);
    pc_freeze    = 1'b0;
    if_id_freeze = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    pipe_freeze  = 1'b0;
    // Outputs are forced quiet while reset is asserted, even though the
    // memory handshake inputs may still indicate a stall.
    if (rst_n) begin
      if (mem_stall) begin
        // Whole pipe holds; a taken branch in EX stays put and fires afterwards.
        pc_freeze    = 1'b1;
        if_id_freeze = 1'b1;
        pipe_freeze  = 1'b1;
      end else if (ex_br_taken) begin
        // The hazarding ID instruction is on the wrong path and gets squashed.
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
      end else if (haz) begin
        pc_freeze    = 1'b1;
        if_id_freeze = 1'b1;
        id_ex_flush  = 1'b1;
      end
    end
  end

  // --------------------------------------------------------- stall counter
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (pc_freeze && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  assign mem_timeout = (state_q == FAULT);
  assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl. Two instances share all
// inputs: u_dut (MEM_TIMEOUT=5, CNT_W=8) and u_sat (MEM_TIMEOUT=3, CNT_W=2,
// watchdog and counter-saturation corner). Directed scenarios are followed
// by randomized traffic checked against a behavioural model.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned AW = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic [AW-1:0] id_src1, id_src2, ex_dest, mem_dest;
  logic id_use1, id_use2, ex_wb_en, ex_mem_read, mem_wb_en;
  logic ex_br_taken, mem_req, mem_ready;
`ifdef PIPE_FWD_EN
  logic [AW-1:0] ex_src1, ex_src2, wb_dest;
  logic wb_wb_en;
  logic [1:0] fa0, fb0, fa1, fb1;
`endif

  logic pcf0, iff0, ifl0, ief0, ppf0, to0;
  logic pcf1, iff1, ifl1, ief1, ppf1, to1;
  logic [7:0] cnt0;
  logic [1:0] cnt1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.REG_ADDR_W(AW), .MEM_TIMEOUT(5), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .id_src1(id_src1), .id_src2(id_src2), .id_use1(id_use1), .id_use2(id_use2),
    .ex_wb_en(ex_wb_en), .ex_dest(ex_dest), .ex_mem_read(ex_mem_read),
    .mem_wb_en(mem_wb_en), .mem_dest(mem_dest), .ex_br_taken(ex_br_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
`ifdef PIPE_FWD_EN
    .ex_src1(ex_src1), .ex_src2(ex_src2), .wb_wb_en(wb_wb_en), .wb_dest(wb_dest),
    .fwd_sel_a(fa0), .fwd_sel_b(fb0),
`endif
    .pc_freeze(pcf0), .if_id_freeze(iff0), .if_id_flush(ifl0), .id_ex_flush(ief0),
    .pipe_freeze(ppf0), .mem_timeout(to0), .stall_cnt(cnt0)
  );

  pipeline_hazard_ctrl #(.REG_ADDR_W(AW), .MEM_TIMEOUT(3), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n),
    .id_src1(id_src1), .id_src2(id_src2), .id_use1(id_use1), .id_use2(id_use2),
    .ex_wb_en(ex_wb_en), .ex_dest(ex_dest), .ex_mem_read(ex_mem_read),
    .mem_wb_en(mem_wb_en), .mem_dest(mem_dest), .ex_br_taken(ex_br_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
`ifdef PIPE_FWD_EN
    .ex_src1(ex_src1), .ex_src2(ex_src2), .wb_wb_en(wb_wb_en), .wb_dest(wb_dest),
    .fwd_sel_a(fa1), .fwd_sel_b(fb1),
`endif
    .pc_freeze(pcf1), .if_id_freeze(iff1), .if_id_flush(ifl1), .id_ex_flush(ief1),
    .pipe_freeze(ppf1), .mem_timeout(to1), .stall_cnt(cnt1)
  );

  // ------------------------------------------------------------ reference model
  // Per instance: timeout limit, counter ceiling, fault flag, waiting flag,
  // cycles spent waiting so far, and number of frozen cycles (saturated).
  int unsigned m_lim[2] = '{5, 3};
  int unsigned m_max[2] = '{255, 3};
  bit          m_fault[2];
  bit          m_wait[2];
  int unsigned m_n[2];
  int unsigned m_cnt[2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_fault[k] = 1'b0;
      m_wait[k]  = 1'b0;
      m_n[k]     = 0;
      m_cnt[k]   = 0;
    end
  endtask

  function automatic bit hit(input logic u, input logic [AW-1:0] s, input logic en,
                             input logic [AW-1:0] d);
    return u && en && (s == d);
  endfunction

  function automatic bit exp_haz();
    bit ex_m;
    ex_m = hit(id_use1, id_src1, ex_wb_en, ex_dest) || hit(id_use2, id_src2, ex_wb_en, ex_dest);
`ifdef PIPE_FWD_EN
    return ex_m && ex_mem_read;
`else
    return ex_m || hit(id_use1, id_src1, mem_wb_en, mem_dest) ||
           hit(id_use2, id_src2, mem_wb_en, mem_dest);
`endif
  endfunction

  // {pc_freeze, if_id_freeze, if_id_flush, id_ex_flush, pipe_freeze}
  function automatic logic [4:0] exp_ctl(input int k);
    if (!rst_n)                                   return 5'b00000;
    if ((mem_req && !mem_ready) || m_fault[k])    return 5'b11001;
    if (ex_br_taken)                              return 5'b00110;
    if (exp_haz())                                return 5'b11010;
    return 5'b00000;
  endfunction

`ifdef PIPE_FWD_EN
  function automatic logic [1:0] exp_fwd(input logic [AW-1:0] s);
    if (mem_wb_en && mem_dest == s) return 2'b01;
    if (wb_wb_en && wb_dest == s)   return 2'b10;
    return 2'b00;
  endfunction
`endif

  task automatic model_clock();
    for (int k = 0; k < 2; k++) begin
      if (exp_ctl(k)[4] && m_cnt[k] < m_max[k]) m_cnt[k]++;
      if (!m_fault[k]) begin
        if (!m_wait[k]) begin
          if (mem_req && !mem_ready) begin
            m_wait[k] = 1'b1;
            m_n[k]    = 1;
          end
        end else if (mem_ready) begin
          m_wait[k] = 1'b0;
        end else if (m_n[k] == m_lim[k]) begin
          m_fault[k] = 1'b1;
        end else begin
          m_n[k]++;
        end
      end
    end
  endtask

  task automatic check_now(input string tag);
    chk({tag, "/ctl0"}, {27'd0, pcf0, iff0, ifl0, ief0, ppf0}, {27'd0, exp_ctl(0)});
    chk({tag, "/ctl1"}, {27'd0, pcf1, iff1, ifl1, ief1, ppf1}, {27'd0, exp_ctl(1)});
    chk({tag, "/cnt0"}, {24'd0, cnt0}, m_cnt[0]);
    chk({tag, "/cnt1"}, {30'd0, cnt1}, m_cnt[1]);
    chk({tag, "/to0"},  {31'd0, to0},  {31'd0, m_fault[0]});
    chk({tag, "/to1"},  {31'd0, to1},  {31'd0, m_fault[1]});
`ifdef PIPE_FWD_EN
    chk({tag, "/fa0"}, {30'd0, fa0}, {30'd0, exp_fwd(ex_src1)});
    chk({tag, "/fb0"}, {30'd0, fb0}, {30'd0, exp_fwd(ex_src2)});
    chk({tag, "/fa1"}, {30'd0, fa1}, {30'd0, exp_fwd(ex_src1)});
`endif
  endtask

  // Inputs are applied just after a falling edge; check, clock the model
  // together with the DUT, and return on the next falling edge.
  task automatic step(input string tag);
    #1;
    check_now(tag);
    @(posedge clk);
    if (rst_n) model_clock();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    id_src1 = '0; id_src2 = '0; id_use1 = 1'b0; id_use2 = 1'b0;
    ex_wb_en = 1'b0; ex_dest = '0; ex_mem_read = 1'b0;
    mem_wb_en = 1'b0; mem_dest = '0; ex_br_taken = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0;
`ifdef PIPE_FWD_EN
    ex_src1 = '0; ex_src2 = '0; wb_wb_en = 1'b0; wb_dest = '0;
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    step("rst");
    rst_n = 1'b1;
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    step("reset");
    rst_n = 1'b1;
    step("idle");

    // Test 1: EX RAW hazard on src1
    id_use1 = 1'b1; id_src1 = 4'd3; ex_wb_en = 1'b1; ex_dest = 4'd3;
    step("t1_haz");
    chk("t1_cnt", {24'd0, cnt0}, 32'd1);

    // Test 2: branch overrides the same hazard
    ex_br_taken = 1'b1;
    step("t2_br");
    chk("t2_cnt", {24'd0, cnt0}, 32'd1);
    clear_inputs();

    // Test 3: four-cycle memory wait, then ready
    do_reset();
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) step("t3_wait");
    mem_ready = 1'b1;
    step("t3_done");
    chk("t3_cnt0", {24'd0, cnt0}, 32'd4);
    chk("t3_sat1", {30'd0, cnt1}, 32'd3);
    clear_inputs();
    step("t3_idle");

    // Test 4: watchdog fault, sticky until reset
    do_reset();
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 8; i++) step("t4_wait");
    chk("t4_to0", {31'd0, to0}, 32'd1);
    chk("t4_to1", {31'd0, to1}, 32'd1);
    clear_inputs();
    mem_ready = 1'b1;
    step("t4_sticky");
    chk("t4_pf", {31'd0, ppf0}, 32'd1);
    do_reset();
    step("t4_after");

    // Test 5: asynchronous reset in the middle of a wait
    mem_req = 1'b1; mem_ready = 1'b0;
    step("t5_a");
    step("t5_b");
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_now("t5_async");
    chk("t5_pc", {31'd0, pcf0}, 32'd0);
    @(negedge clk);
    clear_inputs();
    rst_n = 1'b1;
    step("t5_run");

`ifdef PIPE_FWD_EN
    // Test 6a: MEM beats WB in the forward select
    ex_src1 = 4'd5; mem_dest = 4'd5; mem_wb_en = 1'b1; wb_dest = 4'd5; wb_wb_en = 1'b1;
    step("t6a");
    chk("t6a_sel", {30'd0, fa0}, 32'd1);
    clear_inputs();
    // Test 6b: load-use stalls for one cycle
    ex_mem_read = 1'b1; ex_wb_en = 1'b1; ex_dest = 4'd2; id_src2 = 4'd2; id_use2 = 1'b1;
    step("t6b_stall");
    clear_inputs();
    step("t6b_go");
`endif

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      rst_n       = ($urandom_range(0, 59) != 0);
      id_src1     = AW'($urandom_range(0, 3));
      id_src2     = AW'($urandom_range(0, 3));
      ex_dest     = AW'($urandom_range(0, 3));
      mem_dest    = AW'($urandom_range(0, 3));
      id_use1     = 1'($urandom_range(0, 1));
      id_use2     = 1'($urandom_range(0, 1));
      ex_wb_en    = 1'($urandom_range(0, 1));
      ex_mem_read = 1'($urandom_range(0, 1));
      mem_wb_en   = 1'($urandom_range(0, 1));
      ex_br_taken = ($urandom_range(0, 3) == 0);
      mem_req     = 1'($urandom_range(0, 1));
      mem_ready   = ($urandom_range(0, 2) != 0);
`ifdef PIPE_FWD_EN
      ex_src1     = AW'($urandom_range(0, 3));
      ex_src2     = AW'($urandom_range(0, 3));
      wb_dest     = AW'($urandom_range(0, 3));
      wb_wb_en    = 1'($urandom_range(0, 1));
`endif
      if (!rst_n) model_reset();
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
